// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   RegNumWidth : default register index width of the core
//   HzState     : controller state encoding (RUN / FLUSH / BUSY)
package hazard_ctrl_pkg;

  localparam int RegNumWidth = 5;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_FLUSH = 2'd1,
    HZ_BUSY  = 2'd2
  } HzState;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the performance-debug counters.
//   clk   : core clock
//   clr   : synchronous clear, takes priority over inc
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage core. Detects load-use
// hazards, EX redirects and multi-cycle EX occupancy and drives the
// PC/IF-ID enables, ID/EX bubble, EX hold and flush. Keeps saturating
// stall and redirect counters.
//   clk, rst                  : core clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_*   : sources of the instruction in ID
//   ex_rd, ex_mem_read        : destination / load flag of the instruction in EX
//   ex_redirect, ex_busy      : redirect resolved in EX, multi-cycle unit busy
//   pc_write, ifid_write      : front-end write enables
//   idex_bubble, ex_hold      : ID/EX NOP insert, EX freeze
//   flush                     : squash IF/ID and ID/EX
//   stall_cnt, flush_cnt      : load-use stall cycles, redirects taken
//
// state    | meaning
// ---------+----------------------------------------------------------
// HZ_RUN   | normal issue; redirect > busy > load-use > advance
// HZ_FLUSH | extra flush cycles after a redirect, fcnt cycles remain
// HZ_BUSY  | multi-cycle EX op in flight, pipeline frozen
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM_WIDTH = RegNumWidth,
  parameter int FLUSH_CYCLES  = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_NUM_WIDTH-1:0] id_rs1,
  input  logic [REG_NUM_WIDTH-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REG_NUM_WIDTH-1:0] ex_rd,
  input  logic                     ex_mem_read,
  input  logic                     ex_redirect,
  input  logic                     ex_busy,
  output logic                     pc_write,
  output logic                     ifid_write,
  output logic                     idex_bubble,
  output logic                     ex_hold,
  output logic                     flush,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     flush_cnt
);

  HzState         state, state_nxt;
  logic [3:0]     fcnt, fcnt_nxt;
  logic           load_use;
  logic           run_eval;
  logic           stall_inc;
  logic           flush_inc;
  logic [CNT_WIDTH-1:0] stall_raw;
  logic [CNT_WIDTH-1:0] flush_raw;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HZ_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    flush       = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    run_eval    = 1'b0;

    case (state)
      HZ_FLUSH: begin
        // Inputs here belong to squashed instructions and are ignored.
        flush      = 1'b1;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if (fcnt <= 4'd1) begin
          state_nxt = HZ_RUN;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt = fcnt - 4'd1;
        end
      end
      HZ_BUSY: begin
        if (ex_busy) begin
          ex_hold = 1'b1;
        end else begin
          // Release cycle behaves exactly like a RUN cycle.
          run_eval = 1'b1;
        end
      end
      default: run_eval = 1'b1;
    endcase

    if (run_eval) begin
      if (ex_redirect) begin
        flush      = 1'b1;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        flush_inc  = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = HZ_FLUSH;
          fcnt_nxt  = 4'(FLUSH_CYCLES - 1);
        end else begin
          state_nxt = HZ_RUN;
        end
      end else if (ex_busy) begin
        ex_hold   = 1'b1;
        state_nxt = HZ_BUSY;
      end else if (load_use) begin
        idex_bubble = 1'b1;
        stall_inc   = 1'b1;
        state_nxt   = HZ_RUN;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        state_nxt  = HZ_RUN;
      end
    end

    // Reset squashes everything in flight and holds the front end.
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ex_hold     = 1'b0;
      flush       = 1'b1;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      state_nxt   = HZ_RUN;
      fcnt_nxt    = '0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc),
    .count (stall_raw)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush_inc),
    .count (flush_raw)
  );

  // Counters read zero during reset, not only after the clearing edge.
  assign stall_cnt = rst ? '0 : stall_raw;
  assign flush_cnt = rst ? '0 : flush_raw;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int FC = 2;
  localparam int NW = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_busy;

  logic        pc_write, ifid_write, idex_bubble, ex_hold, flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic        n_pc_write, n_ifid_write, n_idex_bubble, n_ex_hold, n_flush;
  logic [NW-1:0] n_stall_cnt, n_flush_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  int flush_left = 0;
  bit busy_lock  = 0;
  int n_stall    = 0;
  int n_flushes  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_NUM_WIDTH(5), .FLUSH_CYCLES(FC), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_busy(ex_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ex_hold(ex_hold), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.REG_NUM_WIDTH(5), .FLUSH_CYCLES(FC), .CNT_WIDTH(NW)) u_narrow (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_busy(ex_busy),
    .pc_write(n_pc_write), .ifid_write(n_ifid_write), .idex_bubble(n_idex_bubble),
    .ex_hold(n_ex_hold), .flush(n_flush), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare against model mid-cycle, advance model at the edge.
  task automatic step(input bit r, input bit redir, input bit busy, input bit mrd,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2);
    bit lu;
    bit e_pc, e_ifid, e_bub, e_hold, e_fl;
    int nfl;
    bit nbl;
    bit add_s, add_f;
    rst = r; ex_redirect = redir; ex_busy = busy; ex_mem_read = mrd;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    #1;
    lu = mrd && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    {e_pc, e_ifid, e_bub, e_hold, e_fl} = 5'b0;
    nfl = 0; nbl = 0; add_s = 0; add_f = 0;
    if (r) begin
      {e_pc, e_ifid, e_bub, e_hold, e_fl} = 5'b00101;
    end else if (flush_left > 0) begin
      e_pc = 1; e_ifid = 1; e_fl = 1;
      nfl = flush_left - 1;
    end else if (busy && (busy_lock || !redir)) begin
      e_hold = 1; nbl = 1;
    end else if (redir) begin
      e_pc = 1; e_ifid = 1; e_fl = 1;
      nfl = FC - 1; add_f = 1;
    end else if (lu) begin
      e_bub = 1; add_s = 1;
    end else begin
      e_pc = 1; e_ifid = 1;
    end

    chk("pc_write",    32'(pc_write),    32'(e_pc));
    chk("ifid_write",  32'(ifid_write),  32'(e_ifid));
    chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    chk("ex_hold",     32'(ex_hold),     32'(e_hold));
    chk("flush",       32'(flush),       32'(e_fl));
    chk("stall_cnt",   32'(stall_cnt),   32'(r ? 0 : sat(n_stall, 16)));
    chk("flush_cnt",   32'(flush_cnt),   32'(r ? 0 : sat(n_flushes, 16)));
    chk("sat_stall_cnt", 32'(n_stall_cnt), 32'(r ? 0 : sat(n_stall, NW)));
    chk("sat_flush_cnt", 32'(n_flush_cnt), 32'(r ? 0 : sat(n_flushes, NW)));
    chk("sat_flush",   32'(n_flush),     32'(e_fl));

    @(posedge clk);
    if (r) begin
      flush_left = 0; busy_lock = 0; n_stall = 0; n_flushes = 0;
    end else begin
      flush_left = nfl; busy_lock = nbl;
      n_stall += int'(add_s);
      n_flushes += int'(add_f);
    end
    #1;
  endtask

  initial begin
    // reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // load-use on rs1, then the load moves on
    step(0, 0, 0, 1, 5, 5, 0, 1, 0);
    step(0, 0, 0, 0, 5, 5, 0, 1, 0);
    // load-use on rs2
    step(0, 0, 0, 1, 7, 1, 7, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // x0 destination and unused source: no stall
    step(0, 0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 5, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // redirect, second redirect during flush is ignored
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 5, 5, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // busy for 4 cycles with load-use pending, bubble on release
    repeat (4) step(0, 0, 1, 1, 5, 5, 0, 1, 0);
    step(0, 0, 0, 1, 5, 5, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // redirect with load-use: redirect wins
    step(0, 1, 0, 1, 5, 5, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // redirect during busy is ignored until busy drops, then taken
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // drive the narrow counters into saturation
    repeat (10) step(0, 0, 0, 1, 3, 3, 3, 1, 1);
    repeat (10) begin
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // reset in the middle of busy
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of flush
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
